// File: rtl/shift_deserializer_pkg.sv
// Shared types and helpers for the serial-in, parallel-out receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_deserializer_pkg;

  // Width of a counter that must represent 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // What the output stage does with the holding register on a given edge.
  typedef enum logic [1:0] {
    HANDOFF_NONE  = 2'd0,  // hold Dout/Valid as they are
    HANDOFF_LOAD  = 2'd1,  // a finished word moves into the holding register
    HANDOFF_DROP  = 2'd2,  // a finished word arrives while the old one is still held
    HANDOFF_DRAIN = 2'd3   // the consumer takes the held word, nothing replaces it
  } handoff_e;

endpackage

// File: rtl/shift_deserializer_core.sv
// Shift register and bit counter that assemble one WIDTH-bit frame from Sin.
// Latency: word/done are combinational in the cycle that samples the last bit.
// Backpressure: none; the core always accepts a sampled bit.
module shift_deserializer_core
  import shift_deserializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] word,
  output logic             done,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  // Bit order of the frame is a build-time choice; pick the matching shift.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      // First bit ends up in word[0] after WIDTH shifts toward the LSB.
      assign shifted = {sin, sreg[WIDTH-1:1]};
    end else begin : g_msb_first
      // First bit ends up in word[WIDTH-1] after WIDTH shifts toward the MSB.
      assign shifted = {sreg[WIDTH-2:0], sin};
    end
  endgenerate

  // Completion detect: a sampled bit that fills the last slot of the frame.
  always_comb begin
    last_bit = (cnt == LAST_BIT);
    done     = shift_en && !clear && last_bit;
  end

  // Frame assembly: clear aborts, a sampled bit shifts in, the last bit wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (clear) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      if (last_bit) begin
        // The finished word leaves through 'word' this cycle; start clean.
        sreg <= '0;
        cnt  <= '0;
      end else begin
        sreg <= shifted;
        cnt  <= cnt + CNT_W'(1);
      end
    end
  end

  assign word      = shifted;
  assign bit_count = cnt;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver with a holding register on a Valid/Ready port.
// Latency: Dout/Valid update on the edge that samples the last bit of a frame.
// Backpressure: next frame keeps shifting while Valid&!Ready; a word finishing then is dropped and Overrun sticks.
module shift_deserializer
  import shift_deserializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       ShiftEn,
  input  logic                       Sin,
  input  logic                       Clear,
  input  logic                       Ready,
  output logic [WIDTH-1:0]           Dout,
  output logic                       Valid,
  output logic                       Overrun,
  output logic [$clog2(WIDTH+1)-1:0] BitCount
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0] word;
  logic             done;
  logic [CNT_W-1:0] bit_count;

  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             overrun_q;
  handoff_e         handoff;

  shift_deserializer_core #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST),
    .CNT_W     (CNT_W)
  ) u_core (
    .clk       (Clk),
    .reset     (Reset),
    .clear     (Clear),
    .shift_en  (ShiftEn),
    .sin       (Sin),
    .word      (word),
    .done      (done),
    .bit_count (bit_count)
  );

  // Decide what happens to the holding register this edge; a consumed word
  // frees the slot in the same cycle, so a finishing frame can replace it.
  always_comb begin
    handoff = HANDOFF_NONE;
    if (done) begin
      if (!valid_q || Ready) begin
        handoff = HANDOFF_LOAD;
      end else begin
        handoff = HANDOFF_DROP;
      end
    end else if (valid_q && Ready) begin
      handoff = HANDOFF_DRAIN;
    end
  end

  // Holding register and Valid flag; Clear only aborts the frame in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (handoff)
        HANDOFF_LOAD: begin
          dout_q  <= word;
          valid_q <= 1'b1;
        end
        HANDOFF_DRAIN: begin
          valid_q <= 1'b0;
        end
        default: begin
          // NONE and DROP leave the held word exactly as it is.
        end
      endcase
    end
  end

  // Sticky over-run: set by a dropped word, cleared only by Reset or Clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      overrun_q <= 1'b0;
    end else if (Clear) begin
      overrun_q <= 1'b0;
    end else if (handoff == HANDOFF_DROP) begin
      overrun_q <= 1'b1;
    end
  end

  assign Dout     = dout_q;
  assign Valid    = valid_q;
  assign Overrun  = overrun_q;
  assign BitCount = bit_count;

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: LSB-first and MSB-first instances on shared inputs.
// Latency: checks every output one edge after each input cycle.
// Backpressure: Ready is driven both directed and random to provoke over-runs.
module tb_shift_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, shift_en, sin, clear, ready;
  logic [W-1:0] dout_l, dout_m;
  logic         valid_l, valid_m, ovr_l, ovr_m;
  logic [3:0]   bcnt_l, bcnt_m;

  int errors = 0;
  int checks = 0;

  // Reference model: the frame as a list of received bits, plus the output slot.
  logic         rx_bits [W];
  int           n_bits;
  logic [W-1:0] exp_dout_l, exp_dout_m;
  logic         exp_valid, exp_ovr;

  always #5 clk = ~clk;

  shift_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .Clk(clk), .Reset(reset), .ShiftEn(shift_en), .Sin(sin), .Clear(clear),
    .Ready(ready), .Dout(dout_l), .Valid(valid_l), .Overrun(ovr_l), .BitCount(bcnt_l)
  );

  shift_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .Clk(clk), .Reset(reset), .ShiftEn(shift_en), .Sin(sin), .Clear(clear),
    .Ready(ready), .Dout(dout_m), .Valid(valid_m), .Overrun(ovr_m), .BitCount(bcnt_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply the rules to one edge worth of inputs.
  task automatic model_edge();
    logic         completed;
    logic [W-1:0] wl, wm;
    completed = 1'b0;
    if (reset) begin
      n_bits = 0; exp_valid = 1'b0; exp_ovr = 1'b0;
      exp_dout_l = '0; exp_dout_m = '0;
    end else begin
      if (clear) begin
        n_bits = 0; exp_ovr = 1'b0;
      end else if (shift_en) begin
        rx_bits[n_bits] = sin;
        n_bits++;
        if (n_bits == W) begin
          completed = 1'b1;
          n_bits = 0;
        end
      end
      if (completed) begin
        for (int i = 0; i < W; i++) begin
          wl[i]       = rx_bits[i];
          wm[W-1-i]   = rx_bits[i];
        end
        if (!exp_valid || ready) begin
          exp_dout_l = wl; exp_dout_m = wm; exp_valid = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (exp_valid && ready) begin
        exp_valid = 1'b0;
      end
    end
  endtask

  // One clock: model on the edge, compare every output on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("dout_lsb", dout_l, exp_dout_l);
    check("dout_msb", dout_m, exp_dout_m);
    check("valid_lsb", valid_l, exp_valid);
    check("valid_msb", valid_m, exp_valid);
    check("overrun_lsb", ovr_l, exp_ovr);
    check("overrun_msb", ovr_m, exp_ovr);
    check("bitcount_lsb", bcnt_l, n_bits);
    check("bitcount_msb", bcnt_m, n_bits);
  endtask

  task automatic drive(input logic sen, input logic s, input logic clr,
                       input logic rdy, input logic rst);
    shift_en = sen; sin = s; clear = clr; ready = rdy; reset = rst;
    tick();
  endtask

  // Send the low nb bits of v, bit 0 first, with 0..maxgap idle cycles before each.
  task automatic send_bits(input logic [W-1:0] v, input int nb, input int maxgap,
                           input logic rdy_last);
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, maxgap)) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, v[i], 1'b0, (i == W-1) ? rdy_last : 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] tx_sreg;
    n_bits = 0; exp_valid = 1'b0; exp_ovr = 1'b0;
    exp_dout_l = '0; exp_dout_m = '0;
    for (int i = 0; i < W; i++) rx_bits[i] = 1'b0;
    reset = 1'b1; shift_en = 1'b0; sin = 1'b0; clear = 1'b0; ready = 1'b0;

    // Reset state
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_dout", dout_l, 8'h00);
    check("reset_valid", valid_l, 1'b0);
    check("reset_overrun", ovr_l, 1'b0);
    check("reset_bitcount", bcnt_l, 0);

    // Bits 0,1,0,1,... back to back, Ready low
    send_bits(8'hAA, W, 0, 1'b0);
    check("aa_dout", dout_l, 8'hAA);
    check("aa_valid", valid_l, 1'b1);
    check("aa_bitcount", bcnt_l, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("aa_consumed", valid_l, 1'b0);
    check("aa_dout_hold", dout_l, 8'hAA);

    // 8'h3C with random gaps; Valid must rise exactly at the 8th bit edge
    send_bits(8'h3C, W-1, 3, 1'b0);
    check("3c_not_early", valid_l, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("3c_valid", valid_l, 1'b1);
    check("3c_dout", dout_l, 8'h3C);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back 12 then 34 with Ready low: 34 dropped
    send_bits(8'h12, W, 0, 1'b0);
    send_bits(8'h34, W, 0, 1'b0);
    check("ovr_dout", dout_l, 8'h12);
    check("ovr_flag", ovr_l, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("clear_ovr", ovr_l, 1'b0);
    check("clear_valid", valid_l, 1'b1);

    // 12 still held, 56 finishes with Ready high on its last bit
    send_bits(8'h56, W, 1, 1'b1);
    check("swap_dout", dout_l, 8'h56);
    check("swap_valid", valid_l, 1'b1);
    check("swap_ovr", ovr_l, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame, then 8'h5C
    send_bits(8'h07, 3, 0, 1'b0);
    check("partial_bitcount", bcnt_l, 3);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_mid_bitcount", bcnt_l, 0);
    send_bits(8'h5C, W, 0, 1'b0);
    check("rst_5c_dout", dout_l, 8'h5C);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Clear mid-frame (ShiftEn in the Clear cycle ignored), then 8'hC5
    send_bits(8'h07, 3, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("clr_mid_bitcount", bcnt_l, 0);
    send_bits(8'hC5, W, 0, 1'b0);
    check("clr_c5_dout", dout_l, 8'hC5);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // MSB-first: sequence 1,0,0,0,0,0,0,1 then 1,1,0,0,0,0,0,0
    send_bits(8'h81, W, 0, 1'b0);
    check("msb_81", dout_m, 8'h81);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(8'h03, W, 0, 1'b0);
    check("msb_c0", dout_m, 8'hC0);
    check("lsb_03", dout_l, 8'h03);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Loopback from an LSB-first parallel-load transmitter on a shared ShiftEn
    tx_sreg = 8'hA5;
    for (int i = 0; i < W; i++) begin
      repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, tx_sreg[0], 1'b0, 1'b0, 1'b0);
      tx_sreg = tx_sreg >> 1;
    end
    check("loopback_a5", dout_l, 8'hA5);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic r_rst, r_clr, r_sen, r_rdy;
      r_rst = ($urandom_range(0, 199) == 0);
      r_clr = ($urandom_range(0, 39) == 0);
      r_sen = ($urandom_range(0, 3) != 0);
      r_rdy = r_clr ? 1'b0 : ($urandom_range(0, 2) == 0);
      drive(r_sen, 1'($urandom_range(0, 1)), r_clr, r_rdy, r_rst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
